// File: rtl/pfgen_stride.sv
// Per-PC stride detector: learns a cache-line delta per PC signature and
// queues delta/weight prefetch ops for the prefetch engine.
module pfgen_stride #(
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned LADDR_W   = 39,
    parameter int unsigned SPTBR_W   = 38,
    parameter int unsigned PCSIGN_W  = 13,
    parameter int unsigned DELTA_W   = 8,
    parameter int unsigned WEIGHT_W  = 4,
    parameter int unsigned LINE_BITS = 6,
    parameter int unsigned THRESH    = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                coretopfg_req_valid,
    output logic                coretopfg_req_retry,
    input  logic [PCSIGN_W-1:0] coretopfg_req_pcsign,
    input  logic [LADDR_W-1:0]  coretopfg_req_laddr,
    input  logic [SPTBR_W-1:0]  coretopfg_req_sptbr,

    output logic                pfgtopfe_op_valid,
    input  logic                pfgtopfe_op_retry,
    output logic [DELTA_W-1:0]  pfgtopfe_op_d,
    output logic [WEIGHT_W-1:0] pfgtopfe_op_w,
    output logic [PCSIGN_W-1:0] pfgtopfe_op_pcsign,
    output logic [LADDR_W-1:0]  pfgtopfe_op_laddr,
    output logic [SPTBR_W-1:0]  pfgtopfe_op_sptbr
);

    localparam int unsigned LINE_W  = LADDR_W - LINE_BITS;
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned RANGE_W = LINE_W - DELTA_W + 1;

    // Stride table state
    logic                v_q     [ENTRIES];
    logic                v_d     [ENTRIES];
    logic [PCSIGN_W-1:0] pc_q    [ENTRIES];
    logic [PCSIGN_W-1:0] pc_d    [ENTRIES];
    logic [SPTBR_W-1:0]  sp_q    [ENTRIES];
    logic [SPTBR_W-1:0]  sp_d    [ENTRIES];
    logic [LINE_W-1:0]   line_q  [ENTRIES];
    logic [LINE_W-1:0]   line_d  [ENTRIES];
    logic [DELTA_W-1:0]  delta_q [ENTRIES];
    logic [DELTA_W-1:0]  delta_d [ENTRIES];
    logic [WEIGHT_W-1:0] conf_q  [ENTRIES];
    logic [WEIGHT_W-1:0] conf_d  [ENTRIES];
    logic [IDX_W-1:0]    rr_q;
    logic [IDX_W-1:0]    rr_d;

    // Output FIFO state; slot 0 is the head presented to the engine
    logic [DELTA_W-1:0]  fd_q  [2];
    logic [DELTA_W-1:0]  fd_d  [2];
    logic [WEIGHT_W-1:0] fw_q  [2];
    logic [WEIGHT_W-1:0] fw_d  [2];
    logic [PCSIGN_W-1:0] fpc_q [2];
    logic [PCSIGN_W-1:0] fpc_d [2];
    logic [LADDR_W-1:0]  fla_q [2];
    logic [LADDR_W-1:0]  fla_d [2];
    logic [SPTBR_W-1:0]  fsp_q [2];
    logic [SPTBR_W-1:0]  fsp_d [2];
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic                op_valid_q;
    logic                op_valid_d;
    logic                req_retry_q;
    logic                req_retry_d;

    // Per-access combinational signals
    logic                accept_c;
    logic                pop_c;
    logic                push_c;
    logic                hit_c;
    logic [IDX_W-1:0]    hit_idx_c;
    logic                free_found_c;
    logic [IDX_W-1:0]    free_idx_c;
    logic [LINE_W-1:0]   line_in_c;
    logic [LINE_W-1:0]   nd_c;
    logic [RANGE_W-1:0]  nd_hi_c;
    logic                nd_in_range_c;
    logic [DELTA_W-1:0]  nd_lo_c;
    logic [DELTA_W-1:0]  old_delta_c;
    logic [WEIGHT_W-1:0] old_conf_c;
    logic [DELTA_W-1:0]  new_delta_c;
    logic [WEIGHT_W-1:0] new_conf_c;
    logic                fifo_slot_c;

    assign accept_c  = coretopfg_req_valid && !req_retry_q;
    assign pop_c     = op_valid_q && !pfgtopfe_op_retry;
    assign line_in_c = coretopfg_req_laddr[LADDR_W-1:LINE_BITS];

    // Associative lookup on {pcsign, sptbr}
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (v_q[i] && (pc_q[i] == coretopfg_req_pcsign) &&
                (sp_q[i] == coretopfg_req_sptbr)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    // Lowest-index invalid entry, scanned high to low so the lowest wins
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!v_q[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
    end

    // Stride/confidence update for the hit entry
    always_comb begin
        old_delta_c   = delta_q[hit_idx_c];
        old_conf_c    = conf_q[hit_idx_c];
        nd_c          = line_in_c - line_q[hit_idx_c];
        nd_hi_c       = nd_c[LINE_W-1:DELTA_W-1];
        nd_in_range_c = (&nd_hi_c) || !(|nd_hi_c);
        nd_lo_c       = nd_c[DELTA_W-1:0];
        new_delta_c   = old_delta_c;
        new_conf_c    = old_conf_c;
        if (nd_in_range_c && (nd_lo_c != '0) && (nd_lo_c == old_delta_c)) begin
            if (old_conf_c != {WEIGHT_W{1'b1}}) begin
                new_conf_c = old_conf_c + WEIGHT_W'(1);
            end
        end else if (old_conf_c != '0) begin
            new_conf_c = old_conf_c - WEIGHT_W'(1);
        end else begin
            new_delta_c = nd_in_range_c ? nd_lo_c : '0;
        end
        push_c = accept_c && hit_c && (new_conf_c >= WEIGHT_W'(THRESH)) &&
                 (new_delta_c != '0);
    end

    // Table next state: update on hit, allocate victim on miss
    always_comb begin
        v_d     = v_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        line_d  = line_q;
        delta_d = delta_q;
        conf_d  = conf_q;
        rr_d    = rr_q;
        if (accept_c) begin
            if (hit_c) begin
                line_d[hit_idx_c]  = line_in_c;
                delta_d[hit_idx_c] = new_delta_c;
                conf_d[hit_idx_c]  = new_conf_c;
            end else if (free_found_c) begin
                v_d[free_idx_c]     = 1'b1;
                pc_d[free_idx_c]    = coretopfg_req_pcsign;
                sp_d[free_idx_c]    = coretopfg_req_sptbr;
                line_d[free_idx_c]  = line_in_c;
                delta_d[free_idx_c] = '0;
                conf_d[free_idx_c]  = '0;
            end else begin
                v_d[rr_q]     = 1'b1;
                pc_d[rr_q]    = coretopfg_req_pcsign;
                sp_d[rr_q]    = coretopfg_req_sptbr;
                line_d[rr_q]  = line_in_c;
                delta_d[rr_q] = '0;
                conf_d[rr_q]  = '0;
                rr_d = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
            end
        end
    end

    // Output FIFO next state: pop shifts slot 1 to head, push fills next free slot
    always_comb begin
        fd_d        = fd_q;
        fw_d        = fw_q;
        fpc_d       = fpc_q;
        fla_d       = fla_q;
        fsp_d       = fsp_q;
        cnt_d       = cnt_q;
        fifo_slot_c = 1'b0;
        if (pop_c) begin
            fd_d[0]  = fd_q[1];
            fw_d[0]  = fw_q[1];
            fpc_d[0] = fpc_q[1];
            fla_d[0] = fla_q[1];
            fsp_d[0] = fsp_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push_c) begin
            fifo_slot_c        = (cnt_d != 2'd0);
            fd_d[fifo_slot_c]  = new_delta_c;
            fw_d[fifo_slot_c]  = new_conf_c;
            fpc_d[fifo_slot_c] = coretopfg_req_pcsign;
            fla_d[fifo_slot_c] = coretopfg_req_laddr;
            fsp_d[fifo_slot_c] = coretopfg_req_sptbr;
            cnt_d              = cnt_d + 2'd1;
        end
        op_valid_d  = (cnt_d != 2'd0);
        req_retry_d = (cnt_d == 2'd2);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                v_q[i]     <= 1'b0;
                pc_q[i]    <= '0;
                sp_q[i]    <= '0;
                line_q[i]  <= '0;
                delta_q[i] <= '0;
                conf_q[i]  <= '0;
            end
            for (int j = 0; j < 2; j++) begin
                fd_q[j]  <= '0;
                fw_q[j]  <= '0;
                fpc_q[j] <= '0;
                fla_q[j] <= '0;
                fsp_q[j] <= '0;
            end
            rr_q        <= '0;
            cnt_q       <= 2'd0;
            op_valid_q  <= 1'b0;
            req_retry_q <= 1'b0;
        end else begin
            v_q         <= v_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            line_q      <= line_d;
            delta_q     <= delta_d;
            conf_q      <= conf_d;
            fd_q        <= fd_d;
            fw_q        <= fw_d;
            fpc_q       <= fpc_d;
            fla_q       <= fla_d;
            fsp_q       <= fsp_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            op_valid_q  <= op_valid_d;
            req_retry_q <= req_retry_d;
        end
    end

    assign coretopfg_req_retry = req_retry_q;
    assign pfgtopfe_op_valid   = op_valid_q;
    assign pfgtopfe_op_d       = fd_q[0];
    assign pfgtopfe_op_w       = fw_q[0];
    assign pfgtopfe_op_pcsign  = fpc_q[0];
    assign pfgtopfe_op_laddr   = fla_q[0];
    assign pfgtopfe_op_sptbr   = fsp_q[0];

endmodule

// File: doc/pfgen_stride.md
# pfgen_stride

Per-PC stride detector that generates prefetch operations. It observes the core's demand load stream and learns a cache-line delta for each PC signature. Once a stride is confirmed, it issues delta/weight operations on the `pfgtopfe_op` channel. It sits directly upstream of the prefetch engine and drives that engine's `pfgtopfe_op_*` inputs.

## Interface
- `ENTRIES`, 8: number of fully associative stride-table entries (power of 2).
- `LADDR_W`, 39: width of `SC_laddr_type`.
- `SPTBR_W`, 38: width of `SC_sptbr_type`.
- `PCSIGN_W`, 13: width of `SC_pcsign_type`.
- `DELTA_W`, 8: width of `PF_delta_type`. Signed, in cache lines.
- `WEIGHT_W`, 4: width of `PF_weigth_type`. Unsigned confidence.
- `LINE_BITS`, 6: log2 of the line size in bytes.
- `THRESH`, 2: minimum confidence required to emit an op.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low. The block is in reset when `reset` is 0 at a `clk` edge.
- `coretopfg_req_valid`, in, 1: a demand load is observed.
- `coretopfg_req_retry`, out, 1: the load is not accepted this cycle.
- `coretopfg_req_pcsign`, in, PCSIGN_W: PC signature of the load.
- `coretopfg_req_laddr`, in, LADDR_W: load address.
- `coretopfg_req_sptbr`, in, SPTBR_W: address-space root of the load.
- `pfgtopfe_op_valid`, out, 1: a prefetch op is presented to the engine.
- `pfgtopfe_op_retry`, in, 1: the engine stalls the op.
- `pfgtopfe_op_d`, out, DELTA_W: stride in lines.
- `pfgtopfe_op_w`, out, WEIGHT_W: confidence.
- `pfgtopfe_op_pcsign`, out, PCSIGN_W: PC signature of the triggering load.
- `pfgtopfe_op_laddr`, out, LADDR_W: address of the triggering load.
- `pfgtopfe_op_sptbr`, out, SPTBR_W: address-space root of the triggering load.

## Operation
- **Handshake.** A transfer occurs when valid=1 and retry=0 in the same cycle. `coretopfg_req_retry` = (output FIFO count == 2), decoded from registered state only.
- **Table entry fields.** Each entry holds: v, pcsign, sptbr, line (LADDR_W-LINE_BITS bits), delta (DELTA_W bits), conf (WEIGHT_W bits).
- **Lookup.** An accepted load computes `line_in = laddr >> LINE_BITS`. A hit is an entry with v=1, matching pcsign and matching sptbr. At most one entry hits.
- **Hit case:**
  - Compute `nd = line_in - entry.line` at full width.
  - `nd` is in range when it lies within the signed DELTA_W range, −128..127 by default.
  - If `nd` is in range, nonzero, and equal to `entry.delta`: conf increments, saturating at all-ones (15).
  - Else if conf > 0: conf decrements by 1 and delta is kept.
  - Else (conf == 0): delta is set to `nd`, or to 0 if `nd` is out of range, and conf stays 0.
  - In all hit cases, line is set to `line_in`.
- **Miss case:**
  - The victim is the lowest-index entry with v=0. If all entries are valid, the victim is the round-robin pointer's entry.
  - The round-robin pointer advances only when it supplies the victim, wrapping ENTRIES-1 → 0.
  - The victim is written with v=1, pcsign, sptbr, `line_in`, delta=0, conf=0.
- **Emit.** When the updated conf ≥ THRESH and delta ≠ 0, push into the output FIFO: {d=delta, w=conf, pcsign, laddr, sptbr}, using the updated values.
  - A miss never emits.
  - The FIFO cannot overflow, because retry blocks acceptance whenever the FIFO is full.
- **Output FIFO.**
  - 2-entry, in-order.
  - `pfgtopfe_op_*` is driven from the head register.
  - The head is popped on a transfer.
  - A push and a pop may occur in the same cycle.
- **Update timing.** The table is updated at the accept edge, so a back-to-back load with the same pcsign sees the updated entry.
- **Reset.** Entries go invalid, the round-robin pointer goes to 0, and the FIFO empties. Reset mid-stream discards any queued ops.

## Timing
- **Latency.** A load accepted at edge N with an emitting update produces `pfgtopfe_op_valid`=1 in cycle N+1 if the FIFO was empty. Otherwise the op appears after the ops queued ahead of it.
- **Throughput.** One load per cycle while count < 2. One op per cycle when the engine is not retrying.
- **Output stability.** While `pfgtopfe_op_valid`=1 and `pfgtopfe_op_retry`=1, all `pfgtopfe_op_*` outputs hold stable.
- **Reset values.** `pfgtopfe_op_valid`=0, `coretopfg_req_retry`=0, and `pfgtopfe_op_d/w/pcsign/laddr/sptbr`=0.
- **Full FIFO.** When count==2, retry is 1 for that entire cycle, even if the engine pops in the same cycle. Retry drops in the cycle after the pop.

## Test plan
- **Stride learning.** pcsign 0x10, sptbr 1, laddr 0x1000, 0x1040, 0x1080, 0x10C0, one load per cycle, engine retry=0.
  - First load misses (allocate). Second load sets delta=1 with conf 0. Third load: conf 1, no op. Fourth load: conf 2 → one op {d=1, w=2, laddr=0x10C0} at the next cycle.
- **Negative stride.** Loads at 0x2000, 0x1F80, 0x1F00, 0x1E80.
  - Required op: d=−2 (0xFE), w=2.
- **Out-of-range delta.** Load at 0x0, then a load at (200<<6).
  - delta stays 0, no op. An entry with conf 3 that sees a mismatching load decrements to conf 2 and keeps its delta.
- **Backpressure.** Hold engine retry=1 while a trained stream continues.
  - The FIFO fills after 2 ops, coretopfg retry goes 1, and the op outputs stay stable.
  - Release retry: ops drain in order, and retry deasserts the cycle after the first pop.
- **Replacement.** 9 distinct pcsigns with 8 entries.
  - The 9th load evicts entry 0. A 10th new pcsign evicts entry 1. sptbr isolation: the same pcsign under a different sptbr misses.
- **Reset mid-stream.** Drive reset=0 for one edge while 2 ops are queued.
  - op valid goes 0 next cycle. A following load of a previously trained pcsign misses.
